// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and IDLE -> ACCESS -> RESP sequencer in front of the single-port data_mem.
// Latches the winning request, drives the memory strobes for one cycle and returns a one-cycle ack.
module data_mem_arbiter #(
  parameter int WORD       = 32,
  parameter int MEM_BYTES  = 1000,
  parameter int FIXED_PRIO = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            we0,
  input  logic            we1,
  input  logic            lock0,
  input  logic            lock1,
  input  logic [WORD-1:0] addr0,
  input  logic [WORD-1:0] addr1,
  input  logic [WORD-1:0] wdata0,
  input  logic [WORD-1:0] wdata1,
  output logic            ack0,
  output logic            ack1,
  output logic            err0,
  output logic            err1,
  output logic [WORD-1:0] rdata0,
  output logic [WORD-1:0] rdata1,
  output logic [1:0]      grant,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  output logic            mem_write,
  output logic            mem_read,
  input  logic [WORD-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [1:0]      grant_d;
  logic            rr_last, rr_last_d;
  logic            load;
  logic            load_port;
  logic            lat_we;
  logic [WORD-1:0] lat_addr;
  logic [WORD-1:0] lat_wdata;
  logic            lat_err;
  logic [WORD:0]   end_addr;
  logic            legal;
  logic            in_access;
  logic            in_resp;

  // One extra bit keeps addresses near 2^WORD from wrapping into the legal range.
  assign end_addr  = {1'b0, lat_addr} + (WORD+1)'(3);
  assign legal     = end_addr < (WORD+1)'(MEM_BYTES);
  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    rr_last_d = rr_last;
    load      = 1'b0;
    load_port = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          if (FIXED_PRIO != 0)    load_port = !req0;
          else if (req0 && req1)  load_port = !rr_last;
          else                    load_port = req1;
          load      = 1'b1;
          rr_last_d = load_port;
          grant_d   = load_port ? 2'b10 : 2'b01;
          state_d   = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        // Only the current owner's lock counts; a loser's lock is ignored.
        if (grant[0] && lock0 && req0) begin
          load      = 1'b1;
          load_port = 1'b0;
          state_d   = ACCESS;
        end else if (grant[1] && lock1 && req1) begin
          load      = 1'b1;
          load_port = 1'b1;
          state_d   = ACCESS;
        end else begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rr_last   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_err   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      rr_last <= rr_last_d;
      if (load) begin
        lat_we    <= load_port ? we1    : we0;
        lat_addr  <= load_port ? addr1  : addr0;
        lat_wdata <= load_port ? wdata1 : wdata0;
      end
      if (in_access) begin
        lat_err <= !legal;
        if (legal && !lat_we) begin
          if (grant[0]) rdata0 <= mem_rdata;
          else          rdata1 <= mem_rdata;
        end
      end
    end
  end

  assign mem_write = in_access && legal && lat_we;
  assign mem_read  = in_access && legal && !lat_we;
  assign mem_addr  = (in_access && legal) ? lat_addr : '0;
  assign mem_wdata = mem_write ? lat_wdata : '0;

  assign ack0 = in_resp && grant[0];
  assign ack1 = in_resp && grant[1];
  assign err0 = ack0 && lat_err;
  assign err1 = ack1 && lat_err;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: byte-array data_mem model, round-robin and fixed-priority
// instances driven by the same requests, hand-computed expected values.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [1:0]  grant;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic        f_ack0, f_ack1, f_err0, f_err1;
  logic [31:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_wdata;
  logic [1:0]  f_grant;
  logic        f_mem_write, f_mem_read;

  logic [7:0]  mem [0:999];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WORD(32), .MEM_BYTES(1000), .FIXED_PRIO(0)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .grant(grant),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  data_mem_arbiter #(.WORD(32), .MEM_BYTES(1000), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1),
    .rdata0(f_rdata0), .rdata1(f_rdata1), .grant(f_grant),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write), .mem_read(f_mem_read),
    .mem_rdata(32'h0)
  );

  // data_mem model: combinational little-endian read, write commits on the negedge.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr < 32'd997)
      mem_rdata = {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
  end

  always @(negedge clk) begin
    if (mem_write && mem_addr < 32'd997) begin
      mem[mem_addr]   <= mem_wdata[7:0];
      mem[mem_addr+1] <= mem_wdata[15:8];
      mem[mem_addr+2] <= mem_wdata[23:16];
      mem[mem_addr+3] <= mem_wdata[31:24];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issues one unlocked access from IDLE, waits (bounded) for its ack, then returns to IDLE.
  task automatic do_access(input bit port, input logic w, input logic [31:0] a, input logic [31:0] d,
                           input string tag, output logic e, output int wr, output int rd);
    int lat;
    bit seen;
    lat = 0; seen = 0; wr = 0; rd = 0; e = 1'b0;
    if (!port) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else       begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      lat++;
      if (mem_write) wr++;
      if (mem_read)  rd++;
      if (port ? ack1 : ack0) begin
        seen = 1'b1;
        e    = port ? err1 : err0;
      end
    end
    check({tag, "_latency"}, lat, 2);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
  endtask

  localparam logic [31:0] LOCK_EXP [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic e;
    int   wr, rd, n, fix0, fix1, acks;
    logic [1:0] g [4];

    for (int i = 0; i < 1000; i++) mem[i] = 8'(i);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

    // Reset state
    do_reset();
    check("rst_grant", grant, 2'b00);
    check("rst_ack0", ack0, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rdata0", rdata0, 0);

    // Write then read back on port 0
    do_access(0, 1, 32'h10, 32'hDEADBEEF, "wr10", e, wr, rd);
    check("wr10_err", e, 0);
    check("wr10_write_cycles", wr, 1);
    check("wr10_mem_byte", mem[16], 8'hEF);
    do_access(0, 0, 32'h10, 32'h0, "rd10", e, wr, rd);
    check("rd10_err", e, 0);
    check("rd10_read_cycles", rd, 1);
    check("rd10_rdata0", rdata0, 32'hDEADBEEF);

    // Round-robin vs fixed priority with both ports requesting continuously
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 0; addr1 = 4;
    n = 0; fix0 = 0; fix1 = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (mem_read && n < 4) begin g[n] = grant; n++; end
      if (f_grant == 2'b10) fix1++;
      if (f_grant == 2'b01) fix0++;
    end
    check("rr_grant0", g[0], 2'b01);
    check("rr_grant1", g[1], 2'b10);
    check("rr_grant2", g[2], 2'b01);
    check("rr_grant3", g[3], 2'b10);
    check("fix_port1_grants", fix1, 0);
    check("fix_port0_served", fix0 > 0, 1);
    req0 = 0; req1 = 0;
    tick(); tick(); tick();

    // Locked back-to-back reads on port 1 while port 0 waits
    req1 = 1; we1 = 0; addr1 = 0; lock1 = 1;
    tick();
    req0 = 1; we0 = 0; addr0 = 32'h10; lock0 = 0;
    for (int k = 0; k < 4; k++) begin
      check("lock_grant", grant, 2'b10);
      if (k < 3) addr1 = 32'(4 * (k + 1));
      else       lock1 = 0;
      tick();
      check("lock_ack1", ack1, 1);
      check("lock_ack0_quiet", ack0, 0);
      check("lock_rdata1", rdata1, LOCK_EXP[k]);
      if (k == 3) req1 = 0;
      tick();
    end
    tick();
    check("lock_then_p0_grant", grant, 2'b01);
    tick();
    check("lock_p0_ack", ack0, 1);
    check("lock_p0_rdata0", rdata0, 32'hDEADBEEF);
    req0 = 0;
    tick();

    // Range check at the top of memory
    do_access(1, 1, 32'd997, 32'h12345678, "oor997", e, wr, rd);
    check("oor997_err", e, 1);
    check("oor997_no_write", wr, 0);
    do_access(1, 1, 32'hFFFFFFFE, 32'h12345678, "oorwrap", e, wr, rd);
    check("oorwrap_err", e, 1);
    check("oorwrap_no_write", wr, 0);
    check("oor_mem_intact", {mem[997], mem[998], mem[999]}, 24'hE5E6E7);
    check("oor_rdata1_kept", rdata1, 32'h0F0E0D0C);
    do_access(1, 0, 32'd996, 32'h0, "rd996", e, wr, rd);
    check("rd996_err", e, 0);
    check("rd996_rdata1", rdata1, 32'hE7E6E5E4);

    // Reset in the middle of a port 0 read
    req0 = 1; we0 = 0; addr0 = 32'h4;
    tick();
    check("abort_in_access", mem_read, 1);
    reset = 1; req0 = 0;
    tick();
    reset = 0;
    check("abort_grant", grant, 2'b00);
    check("abort_ack0", ack0, 0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack0 || ack1) acks++;
    end
    check("abort_no_ack", acks, 0);
    do_access(0, 0, 32'h10, 32'h0, "post_abort", e, wr, rd);
    check("post_abort_rdata0", rdata0, 32'hDEADBEEF);

    // Read on port 1, then write on port 0: rdata registers hold
    do_access(1, 0, 32'h8, 32'h0, "rd8", e, wr, rd);
    check("rd8_rdata1", rdata1, 32'h0B0A0908);
    do_access(0, 1, 32'h20, 32'hCAFEF00D, "wr20", e, wr, rd);
    check("wr20_write_cycles", wr, 1);
    check("wr20_rdata1_kept", rdata1, 32'h0B0A0908);
    check("wr20_rdata0_kept", rdata0, 32'hDEADBEEF);
    do_access(1, 0, 32'h20, 32'h0, "rd20", e, wr, rd);
    check("rd20_rdata1", rdata1, 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Strobe exclusivity holds on every cycle.
  always @(negedge clk) begin
    if (!reset && mem_write && mem_read) begin
      n_fail++;
      $display("FAIL strobe_excl: got write=1 read=1 expected at most one");
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port byte-addressed data_mem.
- Port 0 serves the pipeline MEM stage; port 1 serves a secondary master (loader, debug or DMA).
- Each granted request runs a fixed IDLE -> ACCESS -> RESP sequence. The block drives data_mem's address, write-data and strobes, captures read data and returns a one-cycle ack.
- Round-robin or fixed-priority selection; optional lock gives back-to-back accesses to one master; out-of-range addresses are rejected with an error ack.

Parameters:
- WORD, 32, data and address width.
- MEM_BYTES, 1000, byte capacity of the attached data_mem.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- req0, req1  in  1 each  access request; held high until the matching ack.
- we0, we1  in  1 each  1 = write, 0 = read; sampled with req.
- lock0, lock1  in  1 each  keep grant for the next access if req is still high in RESP.
- addr0, addr1  in  WORD each  byte address.
- wdata0, wdata1  in  WORD each  write data.
- ack0, ack1  out  1 each  one-cycle completion pulse.
- err0, err1  out  1 each  valid with ack; 1 = address out of range, no memory access done.
- rdata0, rdata1  out  WORD each  registered read data; valid with ack for reads.
- grant  out  2  one-hot owner of the current ACCESS/RESP; 00 in IDLE.
- mem_addr  out  WORD  to data_mem read_addr.
- mem_wdata  out  WORD  to data_mem write_data.
- mem_write  out  1  to data_mem mem_write.
- mem_read  out  1  to data_mem mem_read.
- mem_rdata  in  WORD  from data_mem read_data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state IDLE; grant 00; all outputs 0; rr_last = 1, so port 0 wins the first tie.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise pick a winner and latch its we, addr and wdata into internal registers. Later changes on the input side have no effect.
  - Go to ACCESS. grant reflects the winner from the next cycle.
- Selection:
  - FIXED_PRIO=1: port 0 whenever req0 is high.
  - FIXED_PRIO=0: with both requesting, the port not named by rr_last wins. rr_last updates to the winner on each grant.
  - A single requester always wins.
- Range check: an access is legal when latched addr + 3 < MEM_BYTES. Compare using WORD+1 bits so addr near 2^WORD does not wrap.
- ACCESS, exactly 1 cycle:
  - Legal write: mem_addr and mem_wdata from the latches, mem_write=1 for the whole cycle; data_mem commits on the mid-cycle negedge.
  - Legal read: mem_read=1; mem_rdata is captured into the winner's rdata at the closing posedge.
  - Illegal address: both strobes stay 0 and the err flag is latched.
  - Go to RESP.
- RESP, 1 cycle:
  - Winner's ack=1 and err per the latched flag; the other port's ack=0. Strobes 0; mem_addr and mem_wdata return to 0.
  - If the winner's lock=1 and its req is still high, latch that port's new we/addr/wdata, go to ACCESS and leave rr_last unchanged.
  - Otherwise go to IDLE.
- Latency and throughput: ack arrives 2 cycles after the request is accepted in IDLE. Unlocked throughput is 1 access per 3 cycles; locked throughput is 1 per 2 cycles.
- Requester rule: drop req or present new fields in the cycle after ack. A req still high in IDLE after an ack is treated as a new request.
- rdata holds its value until that port's next read completes. Writes and err acks leave rdata unchanged.
- Simultaneous events:
  - A req arriving during ACCESS or RESP waits; no queue depth beyond the held req.
  - A lock asserted by the losing port has no effect.
- Reset mid-operation:
  - Next posedge forces IDLE, grant 00, all strobes and acks 0, rr_last = 1; no ack is issued for the aborted access.
  - A write whose ACCESS negedge already occurred stays committed in memory.
- mem_write and mem_read are never 1 simultaneously, and never 1 outside ACCESS.

Test Plan:
- Reset, then req0 write of 0xDEADBEEF to addr 0x10; later req0 read of 0x10 -> mem_write high exactly one cycle; read-ack cycle has ack0=1, err0=0, rdata0=0xDEADBEEF.
- req0 and req1 both asserted continuously, FIXED_PRIO=0, locks 0 -> grants alternate 01,10,01,10, starting with port 0; with FIXED_PRIO=1 port 1 never granted while req0 is high.
- lock1=1 with four back-to-back reads on port 1 at 0x0,0x4,0x8,0xC while req0 is high -> four acks on port 1, 2 cycles apart, before port 0 is granted.
- addr1=MEM_BYTES-3 (997) write, then addr1=0xFFFFFFFE -> ack1=1, err1=1 both times, mem_write never asserted, memory contents unchanged.
- Reset asserted during ACCESS of a port 0 read -> no ack0, grant 00 next cycle, a subsequent request is served normally.
- Read from port 1 followed by a write from port 0 -> rdata1 retains the read value, rdata0 unchanged by the write.
